// File: rtl/ps2_defs.sv
// Shared definitions for the PS/2 device-to-host receive path: frame FSM
// states, frame-format constants and the odd-parity check.
package ps2_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;
  localparam int   PS2_DATA_BITS = 8;

  // PS/2 uses odd parity: the data bits plus the parity bit hold an odd count of ones.
  function automatic logic ps2ParityOk(input logic [PS2_DATA_BITS-1:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only follows
// the synchronized line after FILTER_LEN identical consecutive samples.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Idle bus is high, so every stage resets to 1 to avoid a false edge on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: conditions the raw lines, deserializes
// 11-bit frames and hands good bytes to a one-entry valid/ready holding register.
module ps2_rx_frame
  import ps2_defs::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       rx_overrun,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PS2_DATA_BITS - 1);

  ps2_state_t r_state;
  ps2_state_t w_stateNext;

  logic          w_clkFilt;
  logic          w_dataFilt;
  logic          r_clkPrev;
  logic          w_sample;
  logic          w_timeout;
  logic          w_frameGood;
  logic          w_frameBad;
  logic          w_transfer;
  logic [BW-1:0] r_bitCnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_toCnt;
  logic          r_valid;
  logic [7:0]    r_data;
  logic          r_err;
  logic          r_overrun;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clkFilter (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (ps2_clk),
    .o_level (w_clkFilt)
  );

  ps2_sync_filter #(.FILTER_LEN(1)) u_dataFilter (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (ps2_data),
    .o_level (w_dataFilt)
  );

  assign w_sample   = r_clkPrev & ~w_clkFilt;
  assign w_timeout  = (r_state != IDLE) && (r_toCnt == TO_LAST);
  assign w_transfer = r_valid & rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clkPrev <= 1'b1;
      r_state   <= IDLE;
    end else begin
      r_clkPrev <= w_clkFilt;
      r_state   <= w_stateNext;
    end
  end

  // A stalled frame is aborted even if a sample event lands in the same cycle.
  always_comb begin
    w_stateNext = r_state;
    w_frameGood = 1'b0;
    w_frameBad  = 1'b0;
    if (w_timeout) begin
      w_stateNext = IDLE;
      w_frameBad  = 1'b1;
    end else if (w_sample) begin
      case (r_state)
        IDLE: begin
          if (w_dataFilt == PS2_START_BIT) w_stateNext = DATA;
        end
        DATA: begin
          if (r_bitCnt == BIT_LAST) w_stateNext = PARITY;
        end
        PARITY: begin
          w_stateNext = STOP;
        end
        STOP: begin
          w_stateNext = IDLE;
          if ((w_dataFilt == PS2_STOP_BIT) && ps2ParityOk(r_shift, r_parity)) begin
            w_frameGood = 1'b1;
          end else begin
            w_frameBad = 1'b1;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else if (w_timeout) begin
      r_bitCnt <= '0;
    end else if (w_sample) begin
      case (r_state)
        IDLE:   r_bitCnt <= '0;
        DATA: begin
          r_shift[r_bitCnt] <= w_dataFilt;
          r_bitCnt          <= r_bitCnt + 1'b1;
        end
        PARITY: r_parity <= w_dataFilt;
        default: ;
      endcase
    end
  end

  // Saturates rather than wrapping so a stuck bus cannot alias back to a small count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_toCnt <= '0;
    end else if ((r_state == IDLE) || w_sample) begin
      r_toCnt <= '0;
    end else if (r_toCnt != TO_LAST) begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_err     <= w_frameBad;
      r_overrun <= 1'b0;
      if (w_frameGood) begin
        if (!r_valid || w_transfer) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_transfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_valid   = r_valid;
  assign rx_data    = r_data;
  assign rx_err     = r_err;
  assign rx_overrun = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- Upstream stage of the keyboard path. Deserializes device-to-host PS/2 frames from the raw ps2_clk/ps2_data lines into 8-bit scan codes.
- Each frame is 1 start bit, 8 data bits LSB first, 1 odd-parity bit and 1 stop bit. Frames are checked for framing, parity and timeout errors.
- Each good byte is presented on a one-entry valid/ready holding register to the scan-code-to-ASCII/interrupt stage.

Parameters:
- FILTER_LEN, 4: consecutive clk cycles the synchronized ps2_clk must hold a new level before the filtered clock changes.
- TIMEOUT_CYCLES, 4096: clk cycles allowed between successive ps2_clk falling edges inside a frame before it is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock line (idle high).
- ps2_data  in  1  raw PS/2 data line (idle high).
- rx_ready  in  1  downstream can accept rx_data this cycle.
- rx_valid  out  1  rx_data holds an unconsumed scan code.
- rx_data  out  8  received scan code.
- rx_err  out  1  one-cycle pulse: parity, stop-bit or timeout error.
- rx_overrun  out  1  one-cycle pulse: good byte dropped because the holding register was full.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values:
  - rx_valid=0, rx_data=0x00, rx_err=0, rx_overrun=0, busy=0.
  - FSM=IDLE, bit counter=0, timeout counter=0.
  - Synchronizer flops and filtered clock reset to 1 (idle bus). Reset asserted mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - The filtered clock takes the synchronized ps2_clk value only after FILTER_LEN identical consecutive samples. Shorter glitches are ignored.
- Sample event: a cycle where the filtered clock is 0 and its registered previous value is 1. Synchronized ps2_data is sampled in that cycle.
- FSM, one transition per sample event:
  - IDLE: sampled 0 -> DATA, bit counter=0. Sampled 1 -> stay in IDLE, no error.
  - DATA: shift the sampled bit into the shift register at bit[counter] (LSB first), then increment. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP:
    - Good frame when the stop bit=1 and the XOR of the 8 data bits and the parity bit =1. Deliver the byte.
    - Otherwise pulse rx_err the next cycle and discard the byte.
    - Either way -> IDLE.
- Timeout:
  - The counter clears on every sample event and in IDLE, and increments otherwise.
  - If it reaches TIMEOUT_CYCLES-1 while not in IDLE: rx_err pulses the next cycle, FSM -> IDLE, partial data is discarded.
- Delivery latency: a good stop-bit sample event in cycle N gives rx_valid=1 and rx_data updated in cycle N+1.
- Holding register:
  - Transfer occurs when rx_valid && rx_ready. rx_valid clears the next cycle unless a new byte is delivered in the same cycle.
  - Delivery while rx_valid=1 and no transfer that cycle: the new byte is dropped, rx_overrun pulses, rx_data is unchanged.
  - Delivery in the same cycle as a transfer: the new byte loads, rx_valid stays 1, no overrun.
  - Error frames never modify rx_data or rx_valid.
- rx_err and rx_overrun are never simultaneously required; each is a single-cycle pulse.
- Widths: the timeout counter is clog2(TIMEOUT_CYCLES) bits and saturates, with no wrap. The filter counter is clog2(FILTER_LEN+1) bits.

Decomposition:
- Shared package ps2_defs holds:
  - FSM state encodings IDLE/DATA/PARITY/STOP.
  - Constants PS2_START_BIT=0, PS2_STOP_BIT=1, PS2_DATA_BITS=8.
- One sub-module, ps2_sync_filter: 2-flop synchronizer plus stability filter, parameterized by FILTER_LEN. It is used for ps2_clk, and for ps2_data with FILTER_LEN=1.

Test Plan:
- Frame 0x1C: data 0,0,1,1,1,0,0,0; parity 0; stop 1; rx_ready=1. Expect rx_valid pulse with rx_data=0x1C one cycle after the stop edge, rx_err=0.
- Same 0x1C frame with parity bit=1. Expect rx_err single pulse, rx_valid stays 0, rx_data keeps its previous value.
- Start bit plus 3 data bits, then ps2_clk held high for TIMEOUT_CYCLES. Expect rx_err pulse and busy=0. Then a clean 0xF0 frame (parity 1) gives rx_data=0xF0.
- rx_ready=0, send 0x1C then 0x32 (parity 0). Expect rx_overrun pulse at the second stop edge, rx_valid=1, rx_data=0x1C. Raise rx_ready for one cycle: rx_valid falls.
- In IDLE with ps2_data=0, drive a ps2_clk low glitch of FILTER_LEN-1 cycles. Expect busy=0 and no sample. A FILTER_LEN-cycle low does start the frame (busy=1).
- Assert rst mid-frame after 5 data bits, release, send 0x1C. Expect all outputs 0 during reset and exactly one correct 0x1C delivery afterwards.
